// File: rtl/xtea_avalon_engine_if.sv
// ============================================================================
// Module : xtea_avalon_engine_if
// Avalon-MM slave bus bundle for the XTEA accelerator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface xtea_avalon_engine_if;
  logic        address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, write, writedata, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, waitrequest
  );
endinterface

`default_nettype wire

// File: rtl/xtea_avalon_engine.sv
// ============================================================================
// Module : xtea_avalon_engine
// Avalon-MM XTEA coprocessor: two 64-bit ECB lanes, one full cycle per clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module xtea_avalon_engine (
  input logic                 clk,
  input logic                 reset,
  xtea_avalon_engine_if.slave bus
);

  localparam logic [31:0] DELTA  = 32'h9E3779B9;
  localparam int          CYCLES = 32;
  localparam logic [4:0]  LAST   = 5'(CYCLES - 1);

  logic [31:0] r_din  [4];
  logic [31:0] r_key  [4];
  logic [31:0] r_dout [4];
  logic [2:0]  r_wp;
  logic [1:0]  r_rp;
  logic        r_busy;
  logic        r_done;
  logic [4:0]  r_round;
  logic [31:0] r_sum;

  logic [31:0] w_sum_next;
  logic [31:0] w_a0, w_a1, w_b0, w_b1;
  logic        w_wr_ok;
  logic        w_rd_ok;

  function automatic logic [31:0] mix(input logic [31:0] v);
    return ((v << 4) ^ (v >> 5)) + v;
  endfunction

  // Both lanes share sum and key; v1 uses the freshly updated v0 and sum.
  always_comb begin
    w_sum_next = r_sum + DELTA;
    w_a0 = r_din[0] + (mix(r_din[1]) ^ (r_sum + r_key[r_sum[1:0]]));
    w_a1 = r_din[1] + (mix(w_a0) ^ (w_sum_next + r_key[w_sum_next[12:11]]));
    w_b0 = r_din[2] + (mix(r_din[3]) ^ (r_sum + r_key[r_sum[1:0]]));
    w_b1 = r_din[3] + (mix(w_b0) ^ (w_sum_next + r_key[w_sum_next[12:11]]));
  end

  assign w_wr_ok = bus.write && !r_busy;
  assign w_rd_ok = bus.read && !bus.write && bus.address && r_done;

  always_comb begin
    bus.waitrequest = 1'b0;
    bus.readdata    = '0;
    if (bus.write) begin
      bus.waitrequest = r_busy;
    end else if (bus.read) begin
      if (!bus.address)
        bus.readdata = {27'b0, r_wp, r_done, r_busy};
      else if (r_done)
        bus.readdata = r_dout[r_rp];
      else
        bus.waitrequest = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_din[i]  <= '0;
        r_key[i]  <= '0;
        r_dout[i] <= '0;
      end
      r_wp    <= '0;
      r_rp    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_round <= '0;
      r_sum   <= '0;
    end else begin
      // Rounds run in place on the data slots; the result is latched on the last one.
      if (r_busy) begin
        r_din[0] <= w_a0;
        r_din[1] <= w_a1;
        r_din[2] <= w_b0;
        r_din[3] <= w_b1;
        r_sum    <= w_sum_next;
        r_round  <= r_round + 5'd1;
        if (r_round == LAST) begin
          r_dout[0] <= w_a0;
          r_dout[1] <= w_a1;
          r_dout[2] <= w_b0;
          r_dout[3] <= w_b1;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
        end
      end

      if (w_wr_ok) begin
        if (bus.address) begin
          if (r_wp[2])
            r_key[r_wp[1:0]] <= bus.writedata;
          else
            r_din[r_wp[1:0]] <= bus.writedata;
          r_wp <= r_wp + 3'd1;
          if (r_wp == 3'd0) begin
            r_done <= 1'b0;
            r_rp   <= '0;
          end
          if (r_wp == 3'd7) begin
            r_busy  <= 1'b1;
            r_sum   <= '0;
            r_round <= '0;
          end
        end else if (bus.writedata[0]) begin
          r_wp   <= '0;
          r_rp   <= '0;
          r_done <= 1'b0;
        end
      end

      if (w_rd_ok)
        r_rp <= r_rp + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xtea_avalon_engine.sv
// ============================================================================
// Module : tb_xtea_avalon_engine
// Directed self-checking bench for xtea_avalon_engine against a C-style XTEA model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xtea_avalon_engine;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [31:0] words [8];
  logic [63:0] ref_a, ref_b;
  logic [31:0] rd;
  int          stalls;

  xtea_avalon_engine_if bus ();

  xtea_avalon_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference XTEA encipher, 32 cycles, written as the classic C loop.
  function automatic logic [63:0] xtea_ref(input logic [31:0] p0, input logic [31:0] p1,
                                           input logic [31:0] k0, input logic [31:0] k1,
                                           input logic [31:0] k2, input logic [31:0] k3);
    logic [31:0] key [4];
    logic [31:0] v0, v1, sum;
    key[0] = k0; key[1] = k1; key[2] = k2; key[3] = k3;
    v0 = p0; v1 = p1; sum = 32'd0;
    for (int i = 0; i < 32; i++) begin
      v0  = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + key[2'(sum & 32'd3)]));
      sum = sum + 32'h9E3779B9;
      v1  = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + key[2'((sum >> 11) & 32'd3)]));
    end
    return {v0, v1};
  endfunction

  task automatic bus_write(input logic adr, input logic [31:0] data, output int nstall);
    bit ok;
    ok = 1'b0;
    nstall = 0;
    bus.address = adr;
    bus.writedata = data;
    bus.write = 1'b1;
    while (!ok && nstall < 200) begin
      @(negedge clk);
      if (!bus.waitrequest) ok = 1'b1;
      else nstall++;
    end
    check("write_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic adr, output logic [31:0] data, output int nstall);
    bit ok;
    ok = 1'b0;
    nstall = 0;
    data = '0;
    bus.address = adr;
    bus.read = 1'b1;
    while (!ok && nstall < 200) begin
      @(negedge clk);
      if (!bus.waitrequest) begin
        ok = 1'b1;
        data = bus.readdata;
      end else begin
        nstall++;
      end
    end
    check("read_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.read = 1'b0;
  endtask

  task automatic load_words();
    int s;
    for (int i = 0; i < 8; i++) bus_write(1'b1, words[i], s);
    ref_a = xtea_ref(words[0], words[1], words[4], words[5], words[6], words[7]);
    ref_b = xtea_ref(words[2], words[3], words[4], words[5], words[6], words[7]);
  endtask

  task automatic set_known();
    words[0] = 32'h33221100; words[1] = 32'h77665544;
    words[2] = 32'h10fedcba; words[3] = 32'h98765432;
    words[4] = 32'heeff0011; words[5] = 32'haabbccdd;
    words[6] = 32'h9abcdef0; words[7] = 32'h12345678;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.address = 1'b0;
    bus.write = 1'b0;
    bus.writedata = '0;
    bus.read = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_waitreq", 32'(bus.waitrequest), 32'd0);
    check("rst_readdata_idle", bus.readdata, 32'd0);
    bus.read = 1'b1;
    #1;
    check("rst_status", bus.readdata, 32'd0);
    bus.read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Known vector
    set_known();
    load_words();
    bus_read(1'b0, rd, stalls);
    check("status_busy", rd, 32'h1);
    repeat (40) @(posedge clk);
    #1;
    bus_read(1'b0, rd, stalls);
    check("status_done", rd, 32'h2);
    bus_read(1'b1, rd, stalls); check("kv_out0", rd, ref_a[63:32]);
    bus_read(1'b1, rd, stalls); check("kv_out1", rd, ref_a[31:0]);
    bus_read(1'b1, rd, stalls); check("kv_out2", rd, ref_b[63:32]);
    bus_read(1'b1, rd, stalls); check("kv_out3", rd, ref_b[31:0]);

    // Early read stalls until done
    load_words();
    bus_read(1'b1, rd, stalls);
    check("early_stalls", 32'(stalls), 32'd32);
    check("early_data", rd, ref_a[63:32]);

    // Lane equality with all-zero data and key, plus read-pointer wrap
    for (int i = 0; i < 8; i++) words[i] = 32'd0;
    load_words();
    bus_read(1'b1, rd, stalls); check("zero_out0", rd, ref_a[63:32]);
    bus_read(1'b1, rd, stalls); check("zero_out1", rd, ref_a[31:0]);
    bus_read(1'b1, rd, stalls); check("zero_out2", rd, ref_b[63:32]);
    bus_read(1'b1, rd, stalls); check("zero_out3", rd, ref_b[31:0]);
    bus_read(1'b1, rd, stalls); check("zero_wrap", rd, ref_a[63:32]);

    // Write while busy lands in slot 0 once the engine finishes
    set_known();
    load_words();
    bus_write(1'b1, 32'hdeadbeef, stalls);
    check("busy_wr_stalls", 32'(stalls), 32'd32);
    bus_read(1'b0, rd, stalls);
    check("busy_wr_status", rd, 32'h4);

    // Simultaneous read and write: write wins, readdata is zero
    bus.address = 1'b0;
    bus.writedata = 32'h1;
    bus.write = 1'b1;
    bus.read = 1'b1;
    @(negedge clk);
    check("rw_waitreq", 32'(bus.waitrequest), 32'd0);
    check("rw_readdata", bus.readdata, 32'd0);
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus_read(1'b0, rd, stalls);
    check("clear_status", rd, 32'h0);

    // Reset in the middle of an encryption
    load_words();
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    bus.address = 1'b0;
    bus.read = 1'b1;
    #1;
    check("midrst_status", bus.readdata, 32'd0);
    check("midrst_waitreq", 32'(bus.waitrequest), 32'd0);
    bus.read = 1'b0;
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus_read(1'b0, rd, stalls);
    check("postrst_status", rd, 32'h0);
    words[0] = 32'h01234567; words[1] = 32'h89abcdef;
    load_words();
    bus_read(1'b1, rd, stalls); check("reload_out0", rd, ref_a[63:32]);
    bus_read(1'b1, rd, stalls); check("reload_out1", rd, ref_a[31:0]);
    bus_read(1'b1, rd, stalls); check("reload_out2", rd, ref_b[63:32]);
    bus_read(1'b1, rd, stalls); check("reload_out3", rd, ref_b[31:0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
